// File: rtl/fifo_unpack_reader.sv
// Pops DWO-bit words from a FIFO and streams them out as EXTENT lanes of DWI bits,
// least-significant lane first, with a one-word prefetch buffer for gapless output.
module fifo_unpack_reader #(
  parameter int DWI = 16,
  parameter int DWO = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           rempty,
  output logic           rinc,
  input  logic [DWO-1:0] rdata,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [DWI-1:0] m_data,
  output logic           m_sof,
  output logic           underrun,
  input  logic           clr_underrun
);

  localparam int EXTENT = DWO / DWI;
  localparam int LW     = $clog2(EXTENT);
  localparam logic [LW-1:0] LAST_LANE = LW'(EXTENT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_e;

  state_e         state_q;
  logic [DWO-1:0] sr_q;
  logic [DWO-1:0] pf_q;
  logic [LW-1:0]  lane_q;
  logic           vld_q;
  logic           sof_q;
  logic           pf_vld_q;
  logic           inflight_q;
  logic           underrun_q;

  logic fire;
  logic last;
  logic sr_free;
  logic pf_free;
  logic pop;
  logic drained;
  logic uflow;

  always_comb begin
    fire    = vld_q && m_ready;
    last    = fire && (lane_q == LAST_LANE);
    sr_free = !vld_q || last;
    // The prefetch slot counts as free when its word moves into the shifter this cycle.
    pf_free = !pf_vld_q || last;
    pop     = !rst && en && !rempty && !inflight_q && pf_free;
    drained = last && !pf_vld_q && !inflight_q;
    uflow   = (state_q == STREAM) && en && drained;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      pf_q       <= '0;
      lane_q     <= '0;
      vld_q      <= 1'b0;
      sof_q      <= 1'b0;
      pf_vld_q   <= 1'b0;
      inflight_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      inflight_q <= pop;

      if (uflow)             underrun_q <= 1'b1;
      else if (clr_underrun) underrun_q <= 1'b0;

      if (last && pf_vld_q) begin
        sr_q     <= pf_q;
        pf_vld_q <= 1'b0;
        lane_q   <= '0;
        sof_q    <= 1'b1;
        vld_q    <= 1'b1;
      end else if (inflight_q && sr_free) begin
        sr_q   <= rdata;
        lane_q <= '0;
        sof_q  <= 1'b1;
        vld_q  <= 1'b1;
      end else begin
        // An arriving word only lands here while the shifter is busy; the slot is empty then.
        if (inflight_q) begin
          pf_q     <= rdata;
          pf_vld_q <= 1'b1;
        end
        if (last) begin
          vld_q  <= 1'b0;
          sof_q  <= 1'b0;
          lane_q <= '0;
        end else if (fire) begin
          sr_q   <= sr_q >> DWI;
          sof_q  <= 1'b0;
          lane_q <= lane_q + LW'(1);
        end
      end

      case (state_q)
        IDLE:    if (pop) state_q <= FETCH;
        FETCH:   if (inflight_q) state_q <= STREAM;
        STREAM:  if (drained) state_q <= pop ? FETCH : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rinc     = pop;
  assign m_valid  = vld_q;
  assign m_data   = sr_q[DWI-1:0];
  assign m_sof    = sof_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_fifo_unpack_reader.sv
// Scoreboard bench: a queue-based FIFO model pushes the expected lanes of every popped
// word; a negedge monitor pops and compares each accepted lane.
module tb_fifo_unpack_reader;
  localparam int DWI = 16;
  localparam int DWO = 64;
  localparam int EXT = DWO / DWI;

  typedef struct packed {
    logic [DWI-1:0] data;
    logic           sof;
  } lane_t;

  logic           clk = 1'b0;
  logic           rst, en, rinc, m_valid, m_ready, m_sof, underrun, clr_underrun;
  logic           rempty = 1'b1;
  logic [DWO-1:0] rdata = '0;
  logic [DWI-1:0] m_data;

  lane_t          exp_q[$];
  logic [DWO-1:0] fifo[$];
  int             xcyc[$];
  int             checks = 0, failures = 0, rinc_cnt = 0, cyc = 0;
  bit             xfer_now = 0, pop_s = 0, prev_stall = 0;
  logic [DWI-1:0] prev_data = '0;
  logic           prev_sof = 1'b0;

  fifo_unpack_reader #(.DWI(DWI), .DWO(DWO)) dut (
    .clk(clk), .rst(rst), .en(en), .rempty(rempty), .rinc(rinc), .rdata(rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof),
    .underrun(underrun), .clr_underrun(clr_underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // FIFO model: a pop seen at negedge completes at the next posedge; the word is then
  // presented on rdata for one cycle and its lanes become the expected output.
  always @(negedge clk) pop_s <= rinc && !rempty;

  always @(posedge clk) begin : fifo_model
    logic [DWO-1:0] w;
    cyc <= cyc + 1;
    if (pop_s && fifo.size() > 0) begin
      w = fifo.pop_front();
      rdata <= w;
      rinc_cnt++;
      for (int k = 0; k < EXT; k++) exp_q.push_back('{data: w[k*DWI +: DWI], sof: (k == 0)});
    end
    rempty <= (fifo.size() == 0);
  end

  always @(negedge clk) begin : monitor
    lane_t e;
    xfer_now = 0;
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
        check("stall_sof", m_sof, prev_sof);
      end
      if (rinc) begin
        check("rinc_while_empty", rempty, 0);
        check("rinc_while_disabled", en, 1);
      end
      if (m_valid && m_ready) begin
        xfer_now = 1;
        xcyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL lane_unexpected actual=0x%0h required=none", m_data);
        end else begin
          e = exp_q.pop_front();
          check("lane_data", m_data, e.data);
          check("lane_sof", m_sof, e.sof);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_sof   = m_sof;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string name, input int budget, input bit fifo_too);
    int n = 0;
    while (!(exp_q.size() == 0 && !m_valid && (!fifo_too || fifo.size() == 0)) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, (n < budget), 1);
  endtask

  task automatic clear_uf();
    clr_underrun = 1;
    tick();
    clr_underrun = 0;
  endtask

  initial begin
    int base, n;
    rst = 1; en = 0; m_ready = 0; clr_underrun = 0;
    repeat (3) tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_sof", m_sof, 0);
    check("rst_m_data", m_data, 0);
    check("rst_underrun", underrun, 0);
    check("rst_rinc", rinc, 0);
    rst = 0;
    tick();

    // Single known word, continuous accept
    m_ready = 1; en = 1;
    fifo.push_back(64'h0004_0003_0002_0001);
    xcyc.delete();
    wait_out("one_word", 50, 1);
    check("one_word_lanes", xcyc.size(), 4);
    if (xcyc.size() == 4) check("one_word_gapless", xcyc[3] - xcyc[0], 3);
    check("one_word_underrun", underrun, 1);
    clear_uf();
    check("clr_alone", underrun, 0);

    // Eight preloaded random words
    en = 0;
    base = rinc_cnt;
    for (int i = 0; i < 8; i++) fifo.push_back({$urandom, $urandom});
    repeat (3) tick();
    xcyc.delete();
    en = 1;
    wait_out("burst", 200, 1);
    check("burst_lanes", xcyc.size(), 32);
    if (xcyc.size() == 32) check("burst_gapless", xcyc[31] - xcyc[0], 31);
    check("burst_pops", rinc_cnt - base, 8);
    check("burst_underrun", underrun, 1);

    // Accept toggling every cycle
    xcyc.delete();
    for (int i = 0; i < 5; i++) fifo.push_back({$urandom, $urandom});
    n = 0;
    while (!(exp_q.size() == 0 && !m_valid && fifo.size() == 0) && n < 400) begin
      m_ready = ~m_ready;
      tick();
      n++;
    end
    check("toggle_timeout", (n < 400), 1);
    check("toggle_lanes", xcyc.size(), 20);
    m_ready = 1;

    // Clear requested in the very cycle underrun is raised
    clear_uf();
    check("pre_clear", underrun, 0);
    fifo.push_back({$urandom, $urandom});
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(xfer_now && exp_q.size() == 0 && fifo.size() == 0) && n < 100);
    check("same_cycle_found", (n < 100), 1);
    clr_underrun = 1;
    @(posedge clk);
    #1;
    clr_underrun = 0;
    check("set_beats_clear", underrun, 1);
    clear_uf();

    // Enable dropped after lane 1 of word A with word B already fetched
    en = 0;
    for (int i = 0; i < 3; i++) fifo.push_back({$urandom, $urandom});
    repeat (3) tick();
    base = rinc_cnt;
    xcyc.delete();
    en = 1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (xcyc.size() < 2 && n < 100);
    @(posedge clk);
    #1;
    en = 0;
    check("drop_prefetched", rinc_cnt - base, 2);
    wait_out("drop", 100, 0);
    check("drop_lanes", xcyc.size(), 8);
    repeat (10) tick();
    check("drop_no_more_rinc", rinc_cnt - base, 2);
    check("drop_fifo_left", fifo.size(), 1);
    check("drop_no_underrun", underrun, 0);
    check("drop_idle_valid", m_valid, 0);

    // Reset mid-word, then resume from the remaining FIFO contents
    for (int i = 0; i < 3; i++) fifo.push_back({$urandom, $urandom});
    en = 1;
    n = 0;
    while (!(m_valid && !m_sof) && n < 100) begin
      tick();
      n++;
    end
    check("midword_found", (n < 100), 1);
    rst = 1;
    #1;
    check("rst_mid_m_valid", m_valid, 0);
    check("rst_mid_m_sof", m_sof, 0);
    check("rst_mid_m_data", m_data, 0);
    check("rst_mid_underrun", underrun, 0);
    check("rst_mid_rinc", rinc, 0);
    exp_q.delete();
    repeat (2) tick();
    rst = 0;
    xcyc.delete();
    wait_out("after_rst", 200, 1);
    check("after_rst_lanes", xcyc.size() % EXT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
